time_stamp_unit: RTL and testbench

- Free-running time base and per-vector interrupt-entry time-stamp capture for the N-CLIC.
- Sits beside the N-CLIC and feeds the CSR file: it consumes the N-CLIC's interrupt-entry event (vector index) and exposes captured stamps as CSRs at TimeStampCsrBase + vec.
- Also provides the 32-bit monotonic timer to the rest of the core.

---
 rtl/time_stamp_unit.sv | 104 ++++++++++
 tb/tb_time_stamp_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_stamp_unit.sv
// Free-running monotonic timer, prescaled time-stamp counter and per-vector
// interrupt-entry stamp capture, exposed as a block of CSRs.
module time_stamp_unit #(
    parameter int          VecSize            = 8,
    parameter int          TimeStampWidth     = 8,
    parameter int          TimeStampPreScaler = 0,
    parameter int          MonoTimerWidth     = 32,
    parameter logic [11:0] TimeStampCsrBase   = 12'hb40,
    localparam int         VecIdxW            = (VecSize > 1) ? $clog2(VecSize) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      entry_valid,
    input  logic [VecIdxW-1:0]        entry_vec,
    input  logic [11:0]               csr_addr,
    input  logic                      csr_we,
    input  logic [31:0]               csr_wdata,
    output logic                      csr_hit,
    output logic [31:0]               csr_rdata,
    output logic [MonoTimerWidth-1:0] mono_timer,
    output logic [TimeStampWidth-1:0] ts_now,
    output logic                      ts_tick
);

    localparam int PsW = (TimeStampPreScaler > 0) ? TimeStampPreScaler : 1;

    logic [MonoTimerWidth-1:0] mono_r;
    logic [PsW-1:0]            ps_cnt_r;
    logic [TimeStampWidth-1:0] ts_r;
    logic [TimeStampWidth-1:0] cap_r [VecSize];
    logic [VecSize-1:0]        flag_r;

    logic [11:0]               offset_s;
    logic [VecIdxW-1:0]        idx_s;
    logic                      hit_s;
    logic                      tick_s;
    logic [31:0]               rdata_s;

    // Address decode, prescaler terminal detect and CSR read mux.
    always_comb begin
        offset_s = csr_addr - TimeStampCsrBase;
        idx_s    = offset_s[VecIdxW-1:0];
        hit_s    = (offset_s < 12'(VecSize));
        rdata_s  = 32'h0000_0000;
        if (TimeStampPreScaler == 0) begin
            tick_s = 1'b1;
        end else begin
            tick_s = (ps_cnt_r == {PsW{1'b1}});
        end
        if (hit_s) begin
            rdata_s[31]                  = flag_r[idx_s];
            rdata_s[TimeStampWidth-1:0]  = cap_r[idx_s];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Timers, prescaler and time-stamp counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mono_r   <= {MonoTimerWidth{1'b0}};
            ps_cnt_r <= {PsW{1'b0}};
            ts_r     <= {TimeStampWidth{1'b0}};
        end else begin
            mono_r   <= mono_r + {{(MonoTimerWidth-1){1'b0}}, 1'b1};
            ps_cnt_r <= ps_cnt_r + {{(PsW-1){1'b0}}, 1'b1};
            if (tick_s) begin
                ts_r <= ts_r + {{(TimeStampWidth-1){1'b0}}, 1'b1};
            end else begin
                ts_r <= ts_r;
            end
        end
    end

    // Capture registers: an entry on the same index overrides a CSR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_r <= {VecSize{1'b0}};
            for (int v = 0; v < VecSize; v++) begin
                cap_r[v] <= {TimeStampWidth{1'b0}};
            end
        end else begin
            for (int v = 0; v < VecSize; v++) begin
                if (entry_valid && (entry_vec == VecIdxW'(v))) begin
                    cap_r[v]  <= ts_r;
                    flag_r[v] <= 1'b1;
                end else if (csr_we && hit_s && (idx_s == VecIdxW'(v))) begin
                    cap_r[v]  <= csr_wdata[TimeStampWidth-1:0];
                    flag_r[v] <= csr_wdata[31];
                end else begin
                    cap_r[v]  <= cap_r[v];
                    flag_r[v] <= flag_r[v];
                end
            end
        end
    end

    assign csr_hit    = hit_s;
    assign csr_rdata  = rdata_s;
    assign mono_timer = mono_r;
    assign ts_now     = ts_r;
    assign ts_tick    = tick_s;

endmodule

// File: tb/tb_time_stamp_unit.sv
// Self-checking bench for time_stamp_unit: default instance plus a
// prescaled (2^2) instance with a 4-bit monotonic timer to exercise wrap.
module tb_time_stamp_unit;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        entry_valid;
    logic [2:0]  entry_vec;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        csr_hit, csr_hit2;
    logic [31:0] csr_rdata, csr_rdata2;
    logic [31:0] mono_timer;
    logic [3:0]  mono2;
    logic [7:0]  ts_now, ts_now2;
    logic        ts_tick, ts_tick2;

    int checks = 0;
    int failures = 0;

    // reference model state
    int unsigned cyc1, cyc2;
    logic [7:0]  cap_m [8];
    logic        flag_m [8];

    always #50 clk = ~clk;

    time_stamp_unit dut (
        .clk(clk), .reset(reset), .entry_valid(entry_valid), .entry_vec(entry_vec),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_hit(csr_hit), .csr_rdata(csr_rdata), .mono_timer(mono_timer),
        .ts_now(ts_now), .ts_tick(ts_tick)
    );

    time_stamp_unit #(.TimeStampPreScaler(2), .MonoTimerWidth(4)) dut2 (
        .clk(clk), .reset(reset2), .entry_valid(1'b0), .entry_vec(3'd0),
        .csr_addr(12'h000), .csr_we(1'b0), .csr_wdata(32'h0000_0000),
        .csr_hit(csr_hit2), .csr_rdata(csr_rdata2), .mono_timer(mono2),
        .ts_now(ts_now2), .ts_tick(ts_tick2)
    );

    typedef struct {
        logic [11:0] addr;
        logic        hit;
    } hit_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_hit(input logic [11:0] a);
        logic [11:0] off;
        off = a - 12'hb40;
        return off < 12'd8;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [11:0] a);
        logic [11:0] off;
        off = a - 12'hb40;
        if (off < 12'd8) return {flag_m[off[2:0]], 23'd0, cap_m[off[2:0]]};
        return 32'h0000_0000;
    endfunction

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    // Advance one clock edge; the model applies the rules to the inputs now held.
    task automatic tick();
        logic [11:0] off;
        off = csr_addr - 12'hb40;
        if (reset) begin
            cyc1 = 0;
            for (int i = 0; i < 8; i++) begin cap_m[i] = 8'h00; flag_m[i] = 1'b0; end
        end else begin
            if (csr_we && off < 12'd8) begin
                cap_m[off[2:0]]  = csr_wdata[7:0];
                flag_m[off[2:0]] = csr_wdata[31];
            end
            if (entry_valid) begin
                cap_m[entry_vec]  = 8'(cyc1);
                flag_m[entry_vec] = 1'b1;
            end
            cyc1++;
        end
        if (reset2) cyc2 = 0; else cyc2++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    hit_vec_t hit_tab [13];

    initial begin
        hit_tab[0]  = '{12'hb3f, 1'b0};
        hit_tab[1]  = '{12'hb40, 1'b1};
        hit_tab[2]  = '{12'hb41, 1'b1};
        hit_tab[3]  = '{12'hb42, 1'b1};
        hit_tab[4]  = '{12'hb43, 1'b1};
        hit_tab[5]  = '{12'hb44, 1'b1};
        hit_tab[6]  = '{12'hb45, 1'b1};
        hit_tab[7]  = '{12'hb46, 1'b1};
        hit_tab[8]  = '{12'hb47, 1'b1};
        hit_tab[9]  = '{12'hb48, 1'b0};
        hit_tab[10] = '{12'h000, 1'b0};
        hit_tab[11] = '{12'hfff, 1'b0};
        hit_tab[12] = '{12'h340, 1'b0};

        reset = 1'b1; reset2 = 1'b1;
        entry_valid = 1'b0; entry_vec = 3'd0;
        csr_addr = 12'h000; csr_we = 1'b0; csr_wdata = 32'h0000_0000;
        tick();
        reset = 1'b0; reset2 = 1'b0;
        check("reset_mono", mono_timer, 32'd0);
        check("reset_ts", {24'd0, ts_now}, 32'd0);
        check("reset_tick", {31'd0, ts_tick}, 32'd1);
        check("reset_tick2", {31'd0, ts_tick2}, 32'd0);

        // idle run: prescaler-2 tick pattern, dut idle state, 4-bit timer wrap
        for (int k = 0; k <= 16; k++) begin
            if (k <= 8) check("ps2_tick", {31'd0, ts_tick2}, {31'd0, (k == 3 || k == 7)});
            if (k == 9) check("ps2_ts_now", {24'd0, ts_now2}, 32'd2);
            if (k == 10) begin
                check("idle_mono", mono_timer, 32'd10);
                check("idle_ts", {24'd0, ts_now}, 32'd10);
                for (int i = 0; i < 13; i++) begin
                    csr_addr = hit_tab[i].addr;
                    #1;
                    check("hit_table", {31'd0, csr_hit}, {31'd0, hit_tab[i].hit});
                    check("idle_rdata", csr_rdata, 32'h0000_0000);
                end
                csr_addr = 12'h000;
            end
            if (k == 16) check("mono4_wrap", {28'd0, mono2}, 32'd0);
            if (k < 16) tick();
        end

        // capture at ts_now=5
        do_reset();
        idle(5);
        entry_valid = 1'b1; entry_vec = 3'd3;
        tick();
        entry_valid = 1'b0;
        rd("cap_vec3", 12'hb43, 32'h8000_0005);
        rd("cap_vec2_untouched", 12'hb42, 32'h0000_0000);

        // capture and write to the same index: capture wins
        do_reset();
        idle(7);
        entry_valid = 1'b1; entry_vec = 3'd1;
        csr_we = 1'b1; csr_addr = 12'hb41; csr_wdata = 32'h0000_0033;
        tick();
        entry_valid = 1'b0; csr_we = 1'b0;
        rd("same_idx", 12'hb41, 32'h8000_0007);

        // capture and write to different indices: both land
        do_reset();
        idle(7);
        entry_valid = 1'b1; entry_vec = 3'd2;
        csr_we = 1'b1; csr_addr = 12'hb41; csr_wdata = 32'h0000_0033;
        tick();
        entry_valid = 1'b0; csr_we = 1'b0;
        rd("diff_idx_wr", 12'hb41, 32'h0000_0033);
        rd("diff_idx_cap", 12'hb42, 32'h8000_0007);

        // time-stamp wrap: capture at 255, counter returns to 0
        do_reset();
        idle(255);
        check("ts_255", {24'd0, ts_now}, 32'd255);
        entry_valid = 1'b1; entry_vec = 3'd0;
        tick();
        entry_valid = 1'b0;
        check("ts_wrap", {24'd0, ts_now}, 32'd0);
        rd("cap_ff", 12'hb40, 32'h8000_00ff);

        // reset during a capture and write
        entry_valid = 1'b1; entry_vec = 3'd4;
        csr_we = 1'b1; csr_addr = 12'hb45; csr_wdata = 32'h8000_0012;
        reset = 1'b1;
        tick();
        reset = 1'b0; entry_valid = 1'b0; csr_we = 1'b0;
        check("midreset_mono", mono_timer, 32'd0);
        for (int i = 0; i < 8; i++) rd("midreset_rd", 12'hb40 + 12'(i), 32'h0000_0000);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(99) == 0);
            entry_valid = ($urandom_range(2) == 0);
            entry_vec   = 3'($urandom_range(7));
            csr_we      = ($urandom_range(3) == 0);
            csr_addr    = 12'hb3c + 12'($urandom_range(15));
            csr_wdata   = $urandom;
            #1;
            check("rnd_hit", {31'd0, csr_hit}, {31'd0, exp_hit(csr_addr)});
            check("rnd_rdata", csr_rdata, exp_rdata(csr_addr));
            tick();
            check("rnd_mono", mono_timer, cyc1);
            check("rnd_ts", {24'd0, ts_now}, {24'd0, 8'(cyc1)});
            check("rnd_tick", {31'd0, ts_tick}, 32'd1);
            check("rnd_mono2", {28'd0, mono2}, cyc2 % 16);
            check("rnd_ts2", {24'd0, ts_now2}, (cyc2 >> 2) % 256);
            check("rnd_tick2", {31'd0, ts_tick2}, {31'd0, ((cyc2 % 4) == 3)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
